// File: rtl/synth_pkg.sv
// Shared types and constants for the codec boot sequencer: FSM state codes
// (also shown on the seven-segment status display) and I2C word format.
package synth_pkg;

    typedef enum logic [3:0] {
        S_POWERUP = 4'd0,
        S_ISSUE   = 4'd1,
        S_WAIT    = 4'd2,
        S_RETRY   = 4'd3,
        S_SETTLE  = 4'd4,
        S_DONE    = 4'd5,
        S_FAIL    = 4'd6
    } seq_state_e;

    localparam int         I2C_WORD_W        = 16;
    localparam int         RETRY_GAP         = 256;
    localparam logic [6:0] CODEC_ADDR_WM8731 = 7'h1A;

endpackage

// File: rtl/codec_reg_rom.sv
// Fixed codec register-write table; each word is {reg[6:0], val[8:0]}.
module codec_reg_rom
    import synth_pkg::*;
(
    input  logic [3:0]            index,
    output logic [I2C_WORD_W-1:0] word
);

    always_comb begin
        word = '0;
        case (index)
            4'd0:    word = 16'h1E00;  // R15 soft reset
            4'd1:    word = 16'h0C10;
            4'd2:    word = 16'h0E02;
            4'd3:    word = 16'h1000;
            4'd4:    word = 16'h0A00;
            4'd5:    word = 16'h0812;
            4'd6:    word = 16'h0579;
            4'd7:    word = 16'h1201;
            4'd8:    word = 16'h0C00;
            default: word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/codec_init_sequencer.sv
// Boot-time codec configuration: walks the register table over I2C with
// retries, a settle delay after soft reset, and reports ready/fail.
module codec_init_sequencer
    import synth_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADDR    = CODEC_ADDR_WM8731,
    parameter int unsigned NUM_REGS       = 9,
    parameter int unsigned POWERUP_CYCLES = 24576,
    parameter int unsigned SETTLE_CYCLES  = 12288,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rerun,
    input  logic                  i2c_busy,
    input  logic                  i2c_done,
    input  logic                  i2c_nack,
    output logic                  i2c_start,
    output logic [6:0]            i2c_addr,
    output logic [I2C_WORD_W-1:0] i2c_data,
    output logic                  codec_ready,
    output logic                  init_fail,
    output logic [3:0]            status,
    output logic [3:0]            index
);

    localparam logic [16:0] POWERUP_LAST  = 17'(POWERUP_CYCLES - 1);
    localparam logic [16:0] SETTLE_LAST   = 17'(SETTLE_CYCLES - 1);
    localparam logic [16:0] RETRY_LAST    = 17'(RETRY_GAP - 1);
    localparam logic [15:0] TIMEOUT_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_INDEX    = 4'(NUM_REGS - 1);
    localparam logic [1:0]  MAX_RETRY_CNT = 2'(MAX_RETRIES);

    seq_state_e            state;
    logic [16:0]           wait_cnt;
    logic [15:0]           tmo_cnt;
    logic [1:0]            retries;
    logic [3:0]            index_next;
    logic [I2C_WORD_W-1:0] rom_word;

    assign i2c_addr = DEVICE_ADDR;
    assign status   = state;

    // The ROM is addressed with the next index so i2c_data is already valid
    // in the first ISSUE cycle and holds until the transaction's done pulse.
    always_comb begin
        index_next = index;
        case (state)
            S_POWERUP: index_next = 4'd0;
            S_WAIT:
                if (i2c_done && !i2c_nack && index != 4'd0 && index != LAST_INDEX)
                    index_next = index + 4'd1;
            S_SETTLE:
                if (wait_cnt == SETTLE_LAST) index_next = 4'd1;
            S_DONE, S_FAIL:
                if (rerun) index_next = 4'd0;
            default: index_next = index;
        endcase
    end

    codec_reg_rom u_rom (
        .index (index_next),
        .word  (rom_word)
    );

    // Master handshake: i2c_start is a one-cycle request issued only while
    // i2c_busy is low; the master answers with a one-cycle i2c_done, and
    // i2c_nack is meaningful only in that same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_POWERUP;
            i2c_start   <= 1'b0;
            i2c_data    <= '0;
            codec_ready <= 1'b0;
            init_fail   <= 1'b0;
            index       <= 4'd0;
            retries     <= 2'd0;
            wait_cnt    <= 17'd0;
            tmo_cnt     <= 16'd0;
        end else begin
            i2c_start <= 1'b0;
            index     <= index_next;
            i2c_data  <= rom_word;
            case (state)
                S_POWERUP: begin
                    if (wait_cnt == POWERUP_LAST) begin
                        wait_cnt <= 17'd0;
                        retries  <= 2'd0;
                        state    <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 17'd1;
                    end
                end
                S_ISSUE: begin
                    if (!i2c_busy) begin
                        i2c_start <= 1'b1;
                        tmo_cnt   <= 16'd0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // done has priority over a timeout landing in the same cycle
                    if (i2c_done && !i2c_nack) begin
                        if (index == 4'd0) begin
                            wait_cnt <= 17'd0;
                            state    <= S_SETTLE;
                        end else if (index == LAST_INDEX) begin
                            codec_ready <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            retries <= 2'd0;
                            state   <= S_ISSUE;
                        end
                    end else if (i2c_done || tmo_cnt == TIMEOUT_LAST) begin
                        if (retries < MAX_RETRY_CNT) begin
                            retries  <= retries + 2'd1;
                            wait_cnt <= 17'd0;
                            state    <= S_RETRY;
                        end else begin
                            init_fail <= 1'b1;
                            state     <= S_FAIL;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_RETRY: begin
                    if (wait_cnt == RETRY_LAST) begin
                        wait_cnt <= 17'd0;
                        state    <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 17'd1;
                    end
                end
                S_SETTLE: begin
                    if (wait_cnt == SETTLE_LAST) begin
                        wait_cnt <= 17'd0;
                        retries  <= 2'd0;
                        state    <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 17'd1;
                    end
                end
                S_DONE, S_FAIL: begin
                    if (rerun) begin
                        codec_ready <= 1'b0;
                        init_fail   <= 1'b0;
                        retries     <= 2'd0;
                        state       <= S_ISSUE;
                    end
                end
                default: state <= S_POWERUP;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Self-checking bench for codec_init_sequencer: a behavioural I2C master
// answers each start, and a timing model predicts every start and the outcome.
module tb_codec_init_sequencer;

    localparam int P   = 300;
    localparam int S   = 150;
    localparam int T   = 600;
    localparam int N   = 9;
    localparam int MR  = 3;
    localparam int GAP = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rerun = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        i2c_start;
    logic [6:0]  i2c_addr;
    logic [15:0] i2c_data;
    logic        codec_ready;
    logic        init_fail;
    logic [3:0]  status;
    logic [3:0]  index;

    typedef struct {
        int lat;
        int tail;
        bit nack;
        bit hang;
    } resp_t;

    resp_t       resp_q[$];
    int          exp_cyc_q[$];
    logic [15:0] exp_q[$];
    int          obs_cyc[$];
    int          exp_end;
    bit          exp_ready;
    int          exp_index;
    int          nack_plan[16];
    int          hang_entry;
    int          cyc = 0;
    int          base = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] table_words[0:8] = '{16'h1E00, 16'h0C10, 16'h0E02, 16'h1000,
                                      16'h0A00, 16'h0812, 16'h0579, 16'h1201, 16'h0C00};

    codec_init_sequencer #(
        .DEVICE_ADDR    (7'h1A),
        .NUM_REGS       (N),
        .POWERUP_CYCLES (P),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .MAX_RETRIES    (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rerun       (rerun),
        .i2c_busy    (i2c_busy),
        .i2c_done    (i2c_done),
        .i2c_nack    (i2c_nack),
        .i2c_start   (i2c_start),
        .i2c_addr    (i2c_addr),
        .i2c_data    (i2c_data),
        .codec_ready (codec_ready),
        .init_fail   (init_fail),
        .status      (status),
        .index       (index)
    );

    // clock and cycle count; rel() is posedges since the last reset release
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rel();
        return cyc - base;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timing model: walks the table entry by entry, choosing a response for
    // every attempt and predicting when each start appears and how it ends.
    task automatic build_plan(input int first_start, input int fixed_lat);
        int t, lat, tail;
        bit failed, finished;
        resp_t r;
        exp_q.delete();
        exp_cyc_q.delete();
        resp_q.delete();
        t = first_start;
        failed = 0;
        finished = 0;
        for (int e = 0; e < N && !failed && !finished; e++) begin
            for (int a = 0; a <= MR; a++) begin
                lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(2, 30));
                tail = (fixed_lat > 0 || e == 0 || e == N - 1) ? 1 : int'($urandom_range(1, 4));
                exp_cyc_q.push_back(t);
                exp_q.push_back(table_words[e]);
                r.lat  = lat;
                r.tail = tail;
                r.hang = (e == hang_entry);
                r.nack = (a < nack_plan[e]);
                resp_q.push_back(r);
                if (r.hang || r.nack) begin
                    if (a == MR) begin
                        failed    = 1;
                        exp_index = e;
                        exp_end   = r.hang ? t + T : t + lat + 1;
                    end else begin
                        t = r.hang ? t + T + GAP + 1 : t + lat + GAP + 2;
                    end
                end else begin
                    if (e == N - 1) begin
                        finished  = 1;
                        exp_index = e;
                        exp_end   = t + lat + 1;
                    end else if (e == 0) begin
                        t = t + lat + 2 + S;
                    end else begin
                        t = t + lat + tail + 1;
                    end
                    break;
                end
            end
        end
        exp_ready = finished;
    endtask

    // Behavioural I2C master: answers each start from the response queue.
    initial begin : responder
        resp_t       r;
        logic [15:0] w;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && i2c_start === 1'b1) begin
                w = i2c_data;
                aborted = 0;
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                end else begin
                    r.lat = 4; r.tail = 1; r.nack = 0; r.hang = 0;
                end
                i2c_busy = 1'b1;
                @(negedge clk);
                if (!reset) aborted = 1;
                check("start_one_cycle", i2c_start, 0);
                for (int i = 1; i < r.lat; i++) begin
                    @(negedge clk);
                    if (!reset) aborted = 1;
                end
                if (r.hang) begin
                    i2c_busy = 1'b0;
                end else begin
                    if (!aborted) check("data_stable", i2c_data, w);
                    i2c_done = 1'b1;
                    i2c_nack = r.nack;
                    for (int i = 0; i < r.tail; i++) begin
                        @(negedge clk);
                        i2c_done = 1'b0;
                        i2c_nack = 1'b0;
                    end
                    i2c_busy = 1'b0;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", status, 0);
        check("rst_start", i2c_start, 0);
        check("rst_ready", codec_ready, 0);
        check("rst_fail", init_fail, 0);
        check("rst_index", index, 0);
        check("rst_addr", i2c_addr, 7'h1A);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        base = cyc;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (i2c_start === 1'b1) seen = 1;
        end
    endtask

    task automatic run_plan(input string tag, input int reset_at, input int rerun_at);
        int s, k, b;
        logic [15:0] w;
        bit seen;
        k = 0;
        obs_cyc.delete();
        while (exp_q.size() > 0) begin
            s = exp_cyc_q.pop_front();
            w = exp_q.pop_front();
            b = s - rel() + 8;
            if (b < 1) b = 1;
            wait_start(b, seen);
            check({tag, "_start_seen"}, seen, 1);
            if (!seen) begin
                exp_q.delete();
                exp_cyc_q.delete();
                return;
            end
            obs_cyc.push_back(rel());
            check({tag, "_start_cyc"}, rel(), s);
            check({tag, "_start_word"}, i2c_data, w);
            if (k == reset_at) begin
                #2 reset = 1'b0;
                #1;
                check({tag, "_async_start"}, i2c_start, 0);
                check({tag, "_async_ready"}, codec_ready, 0);
                check({tag, "_async_status"}, status, 0);
                exp_q.delete();
                exp_cyc_q.delete();
                resp_q.delete();
                return;
            end
            if (k == rerun_at) begin
                @(negedge clk);
                rerun = 1'b1;
                @(negedge clk);
                rerun = 1'b0;
                check({tag, "_rerun_in_wait"}, status, 2);
            end
            k++;
        end
        while (rel() < exp_end - 1) @(negedge clk);
        check({tag, "_pre_ready"}, codec_ready, 0);
        check({tag, "_pre_fail"}, init_fail, 0);
        @(negedge clk);
        check({tag, "_ready"}, codec_ready, exp_ready);
        check({tag, "_fail"}, init_fail, !exp_ready);
        check({tag, "_status"}, status, exp_ready ? 5 : 6);
        check({tag, "_index"}, index, exp_index);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (i2c_start === 1'b1) cnt++;
        end
        check({tag, "_no_more_starts"}, cnt, 0);
    endtask

    task automatic clear_plan();
        for (int e = 0; e < 16; e++) nack_plan[e] = 0;
        hang_entry = -1;
    endtask

    initial begin : main
        int r0;

        // nominal boot with a fixed 20-cycle master
        clear_plan();
        apply_reset();
        build_plan(P + 1, 20);
        release_reset();
        run_plan("boot", -1, -1);
        if (obs_cyc.size() >= 2) check("settle_gap", (obs_cyc[1] - obs_cyc[0]) >= S, 1);

        // entry 3 NACKed twice, then accepted
        clear_plan();
        nack_plan[3] = 2;
        apply_reset();
        build_plan(P + 1, 0);
        release_reset();
        run_plan("nack3", -1, -1);

        // rerun from DONE skips powerup; rerun while in WAIT is ignored
        clear_plan();
        @(negedge clk);
        r0 = rel();
        build_plan(r0 + 2, 0);
        rerun = 1'b1;
        @(negedge clk);
        rerun = 1'b0;
        check("rerun_status", status, 1);
        check("rerun_ready", codec_ready, 0);
        run_plan("rerun", -1, 0);

        // entry 5 NACKed on every attempt
        clear_plan();
        nack_plan[5] = 4;
        apply_reset();
        build_plan(P + 1, 0);
        release_reset();
        run_plan("fail5", -1, -1);
        expect_quiet("fail5", 600);

        // master silent on entry 2: every attempt times out
        clear_plan();
        hang_entry = 2;
        apply_reset();
        build_plan(P + 1, 0);
        release_reset();
        run_plan("hang2", -1, -1);
        expect_quiet("hang2", 300);

        // reset while entry 4 is in flight, then a clean boot
        clear_plan();
        apply_reset();
        build_plan(P + 1, 0);
        release_reset();
        run_plan("rst4", 4, -1);
        apply_reset();
        build_plan(P + 1, 0);
        release_reset();
        run_plan("rst_again", -1, -1);

        // random NACK counts per entry, all recoverable
        for (int it = 0; it < 2; it++) begin
            clear_plan();
            for (int e = 0; e < N; e++) nack_plan[e] = int'($urandom_range(0, 2));
            apply_reset();
            build_plan(P + 1, 0);
            release_reset();
            run_plan("random", -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed cycle %0d expected end before limit", cyc);
        $fatal(1);
    end

endmodule
